note_lane_engine: RTL and testbench
===================================

NOTE_LANE_ENGINE -- requirements
Module: note_lane_engine

Interface
REQ-001 SHALL provide parameter NUM_LANES, default 4, number of note lanes.
REQ-002 SHALL provide parameter NUM_SLOTS, default 4, number of simultaneously falling notes.
REQ-003 SHALL provide parameter LANE_X0, default 160, x of lane 0 left edge.
REQ-004 SHALL provide parameter LANE_PITCH, default 80, x spacing between lanes.
REQ-005 SHALL provide parameter SPRITE_SIZE, default 50, square note sprite edge in pixels.
REQ-006 SHALL provide parameter SCREEN_H, default 480, visible height.
REQ-007 SHALL provide parameter HIT_LINE, default 400, target y of note top edge.
REQ-008 SHALL provide parameter HIT_WINDOW, default 40, +/- tolerance around HIT_LINE.
REQ-009 SHALL provide parameter FALL_STEP, default 1, pixels advanced per frame.
REQ-010 SHALL have port clk, input, 1, 100 MHz system clock.
REQ-011 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-012 SHALL have port frame_tick, input, 1, one-cycle pulse between frames.
REQ-013 SHALL have ports spawn_valid (in, 1), spawn_lane (in, LW=$clog2(NUM_LANES)), spawn_ready (out, 1): new-note handshake.
REQ-014 SHALL have ports key_valid (in, 1), key_lane (in, LW): one-cycle key press event.
REQ-015 SHALL have ports pix_x (in, 10), pix_y (in, 9): current raster position.
REQ-016 SHALL have ports pix_hit (out, 1), pix_lane (out, LW), pix_u (out, 6), pix_v (out, 6): sprite hit and sprite-local coordinates.
REQ-017 SHALL have ports judge_valid (out, 1), judge_result (out, 2): 00 MISS, 01 HIT, 10 WRONG, 11 EMPTY.
REQ-018 SHALL have ports score (out, 16), miss_count (out, 16), combo (out, 8).

Function
REQ-019 Each slot SHALL hold state IDLE or FALL, lane, and y (10 bits).
REQ-020 spawn_ready SHALL be high iff any slot is IDLE and frame_tick is low; on spawn_valid&&spawn_ready, lowest-index IDLE slot SHALL enter FALL with y=0, lane=spawn_lane, next cycle.
REQ-021 On frame_tick, every FALL slot SHALL add FALL_STEP to y; if result >= SCREEN_H, slot SHALL go IDLE, miss_count SHALL increment (saturating), judge_valid/MISS SHALL pulse next cycle, combo SHALL clear.
REQ-022 Multiple expiries in one frame_tick SHALL add their count to miss_count and produce one MISS pulse.
REQ-023 On key_valid, target SHALL be FALL slot with largest y (ties: lowest index); none -> EMPTY.
REQ-024 Target lane==key_lane and |y-HIT_LINE| <= HIT_WINDOW -> HIT: slot IDLE, score incremented (saturating at 16'hFFFF), combo incremented (saturating at 255).
REQ-025 Otherwise WRONG: no slot change, combo cleared, score unchanged.
REQ-026 Judgement SHALL appear as judge_valid one cycle after key_valid; key judgement SHALL take priority over expiry MISS in the same output cycle.
REQ-027 key_valid with frame_tick in same cycle SHALL judge against pre-increment y; a HIT slot SHALL not also expire.
REQ-028 Pixel path SHALL have 1-cycle latency: pix_hit high iff some FALL slot satisfies x0<=pix_x<x0+SPRITE_SIZE and y<=pix_y<y+SPRITE_SIZE, x0=LANE_X0+lane*LANE_PITCH; lowest index wins overlap; pix_u/pix_v = offsets.

Reset
REQ-029 reset SHALL set all slots IDLE, y=0, score=0, miss_count=0, combo=0, judge_valid=0, judge_result=EMPTY, pix_hit=0, and override all same-cycle events.

Configuration
REQ-030 With NOTE_ENGINE_COMBO_EN defined, HIT SHALL add 1+min(combo>>3,3) to score using pre-hit combo; without it, HIT SHALL add 1 and combo SHALL be constant 0.

Structure
REQ-031 Package note_engine_pkg SHALL hold judge_result encoding, slot state enum, and slot record typedef.
REQ-032 Per-slot state/y update SHALL be sub-module note_slot, instantiated NUM_SLOTS times.

Verification
REQ-033 Reset, spawn lane 2 -> slot 0 FALL y=0, x0=320; spawn_ready low when 4 slots full.
REQ-034 Note reaches y=400 after 400 frame_ticks, key_lane=2 -> judge HIT, score=1, slot IDLE.
REQ-035 Note at y=300, key_lane=2 -> WRONG, score 0, combo 0, note remains.
REQ-036 Note left unhit -> at tick 480 slot IDLE, miss_count=1, MISS pulse.
REQ-037 key_valid and frame_tick same cycle with y=440 -> HIT (pre-increment), no MISS.
REQ-038 NOTE_ENGINE_COMBO_EN: 9 consecutive HITs -> score=10, combo=9; without macro score=9.

Source files
------------

// File: rtl/note_lane_engine_pkg.sv
// note_engine_pkg: shared types for the note lane engine.
//   judge_e      - encoding of the judge_result output
//   slot_state_e - per-slot occupancy state
//   slot_t       - per-slot record (state, lane, y)
//   sat_add16    - 16-bit saturating add used for score and miss counters
package note_engine_pkg;

  typedef enum logic [1:0] {
    JUDGE_MISS  = 2'b00,
    JUDGE_HIT   = 2'b01,
    JUDGE_WRONG = 2'b10,
    JUDGE_EMPTY = 2'b11
  } judge_e;

  typedef enum logic {
    SLOT_IDLE = 1'b0,
    SLOT_FALL = 1'b1
  } slot_state_e;

  // Lane field is sized for up to 16 lanes; narrower lane indices are
  // zero-extended into it.
  localparam int LANE_FIELD_W = 4;
  localparam int Y_W          = 10;

  typedef struct packed {
    slot_state_e             state;
    logic [LANE_FIELD_W-1:0] lane;
    logic [Y_W-1:0]          y;
  } slot_t;

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

endpackage

// File: rtl/note_lane_engine_if.sv
// note_lane_engine_if: spawn / key / judgement handshake bundle.
//   spawn_valid, spawn_lane, spawn_ready - new-note handshake
//   key_valid, key_lane                  - one-cycle key press event
//   judge_valid, judge_result            - registered judgement output
// master: the note source / player side; slave: the engine.
interface note_lane_engine_if #(
  parameter int LW = 2
);
  logic          spawn_valid;
  logic [LW-1:0] spawn_lane;
  logic          spawn_ready;
  logic          key_valid;
  logic [LW-1:0] key_lane;
  logic          judge_valid;
  logic [1:0]    judge_result;

  modport master (
    output spawn_valid, spawn_lane, key_valid, key_lane,
    input  spawn_ready, judge_valid, judge_result
  );

  modport slave (
    input  spawn_valid, spawn_lane, key_valid, key_lane,
    output spawn_ready, judge_valid, judge_result
  );
endinterface

// File: rtl/note_lane_engine_slot.sv
// note_slot: one falling-note slot.
//   clk, reset  - clock, synchronous active-high reset
//   spawn       - load the slot as FALL at y=0 with spawn_lane
//   tick        - frame tick: advance y by FALL_STEP while falling
//   kill        - note was hit: return to IDLE (wins over tick)
//   rec         - current slot record
//   expire      - combinational: this tick pushes the note off screen
module note_slot
  import note_engine_pkg::*;
#(
  parameter int LW        = 2,
  parameter int SCREEN_H  = 480,
  parameter int FALL_STEP = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          spawn,
  input  logic [LW-1:0] spawn_lane,
  input  logic          tick,
  input  logic          kill,
  output slot_t         rec,
  output logic          expire
);

  logic [Y_W:0] y_next;

  always_comb begin
    y_next = {1'b0, rec.y} + (Y_W + 1)'(FALL_STEP);
    expire = tick && (rec.state == SLOT_FALL) && !kill && (int'(y_next) >= SCREEN_H);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rec <= '{state: SLOT_IDLE, lane: '0, y: '0};
    end else if (kill) begin
      rec.state <= SLOT_IDLE;
      rec.y     <= '0;
    end else if (spawn) begin
      rec <= '{state: SLOT_FALL, lane: LANE_FIELD_W'(spawn_lane), y: '0};
    end else if (tick && rec.state == SLOT_FALL) begin
      if (expire) begin
        rec.state <= SLOT_IDLE;
        rec.y     <= '0;
      end else begin
        rec.y <= y_next[Y_W-1:0];
      end
    end
  end

endmodule

// File: rtl/note_lane_engine.sv
// note_lane_engine: rhythm-game note engine (falling notes, key judgement,
// sprite pixel lookup, score keeping).
//   clk, reset            - clock, synchronous active-high reset
//   frame_tick            - one-cycle pulse between frames
//   bus (slave)           - spawn handshake, key events, judgement output
//   pix_x, pix_y          - raster position
//   pix_hit/lane/u/v      - registered sprite hit and sprite-local offsets
//   score, miss_count     - saturating 16-bit counters
//   combo                 - consecutive-hit counter
// Build option: NOTE_ENGINE_COMBO_EN enables combo tracking and the combo
// score bonus; without it every HIT scores 1 and combo stays 0.
module note_lane_engine
  import note_engine_pkg::*;
#(
  parameter int  NUM_LANES   = 4,
  parameter int  NUM_SLOTS   = 4,
  parameter int  LANE_X0     = 160,
  parameter int  LANE_PITCH  = 80,
  parameter int  SPRITE_SIZE = 50,
  parameter int  SCREEN_H    = 480,
  parameter int  HIT_LINE    = 400,
  parameter int  HIT_WINDOW  = 40,
  parameter int  FALL_STEP   = 1,
  localparam int LW          = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                frame_tick,
  note_lane_engine_if.slave   bus,
  input  logic [9:0]          pix_x,
  input  logic [8:0]          pix_y,
  output logic                pix_hit,
  output logic [LW-1:0]       pix_lane,
  output logic [5:0]          pix_u,
  output logic [5:0]          pix_v,
  output logic [15:0]         score,
  output logic [15:0]         miss_count,
  output logic [7:0]          combo
);

  localparam int SW     = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int HIT_LO = HIT_LINE - HIT_WINDOW;
  localparam int HIT_HI = HIT_LINE + HIT_WINDOW;

  slot_t                recs [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] spawn_sel;
  logic [NUM_SLOTS-1:0] kill_sel;
  logic [NUM_SLOTS-1:0] expire_v;

  logic          found_idle;
  logic [SW-1:0] idle_idx;
  logic          spawn_ok;

  logic           tgt_found;
  logic [SW-1:0]  tgt_idx;
  logic [Y_W-1:0] tgt_y;
  logic           tgt_match;
  logic           key_hit;
  logic           key_wrong;
  logic [15:0]    exp_cnt;
  logic [15:0]    score_inc;
  logic [7:0]     combo_next;
  judge_e         judge_next;
  judge_e         judge_result_q;
  logic           judge_valid_q;

  logic          pix_hit_c;
  logic [LW-1:0] pix_lane_c;
  logic [5:0]    pix_u_c;
  logic [5:0]    pix_v_c;
  int            x0;
  int            dx;
  int            dy;

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
    note_slot #(
      .LW        (LW),
      .SCREEN_H  (SCREEN_H),
      .FALL_STEP (FALL_STEP)
    ) u_slot (
      .clk        (clk),
      .reset      (reset),
      .spawn      (spawn_sel[g]),
      .spawn_lane (bus.spawn_lane),
      .tick       (frame_tick),
      .kill       (kill_sel[g]),
      .rec        (recs[g]),
      .expire     (expire_v[g])
    );
  end

  // Spawn goes to the lowest-index idle slot; no spawning on a tick cycle.
  always_comb begin
    found_idle = 1'b0;
    idle_idx   = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (!found_idle && recs[i].state == SLOT_IDLE) begin
        found_idle = 1'b1;
        idle_idx   = SW'(i);
      end
    end
    spawn_ok  = found_idle && !frame_tick;
    spawn_sel = '0;
    if (bus.spawn_valid && spawn_ok) spawn_sel[idle_idx] = 1'b1;
  end

  assign bus.spawn_ready = spawn_ok;

  // Key target: lowest note on screen (largest y), strict compare keeps the
  // lowest index on ties. Judged against the registered (pre-tick) y.
  always_comb begin
    tgt_found = 1'b0;
    tgt_idx   = '0;
    tgt_y     = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (recs[i].state == SLOT_FALL && (!tgt_found || recs[i].y > tgt_y)) begin
        tgt_found = 1'b1;
        tgt_idx   = SW'(i);
        tgt_y     = recs[i].y;
      end
    end
    tgt_match = (recs[tgt_idx].lane == LANE_FIELD_W'(bus.key_lane))
             && (int'(tgt_y) >= HIT_LO) && (int'(tgt_y) <= HIT_HI);
    key_hit   = bus.key_valid && tgt_found && tgt_match;
    key_wrong = bus.key_valid && tgt_found && !tgt_match;
    kill_sel  = '0;
    if (key_hit) kill_sel[tgt_idx] = 1'b1;

    exp_cnt = '0;
    for (int i = 0; i < NUM_SLOTS; i++) exp_cnt = exp_cnt + 16'(expire_v[i]);

    if (bus.key_valid) begin
      judge_next = key_hit ? JUDGE_HIT : (key_wrong ? JUDGE_WRONG : JUDGE_EMPTY);
    end else begin
      judge_next = JUDGE_MISS;
    end
  end

`ifdef NOTE_ENGINE_COMBO_EN
  logic [1:0] bonus;

  // An expiry in the same cycle as a hit counts as happening first.
  always_comb begin
    combo_next = combo;
    if (|expire_v) combo_next = '0;
    if (key_hit) begin
      combo_next = (combo_next == 8'hFF) ? 8'hFF : combo_next + 8'd1;
    end else if (key_wrong) begin
      combo_next = '0;
    end
    bonus     = (combo[7:3] > 5'd3) ? 2'd3 : combo[4:3];
    score_inc = 16'd1 + 16'(bonus);
  end
`else
  always_comb begin
    combo_next = '0;
    score_inc  = 16'd1;
  end
`endif

  // Sprite lookup; descending scan so the lowest index overrides.
  always_comb begin
    pix_hit_c  = 1'b0;
    pix_lane_c = '0;
    pix_u_c    = '0;
    pix_v_c    = '0;
    x0         = 0;
    dx         = 0;
    dy         = 0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      x0 = LANE_X0 + int'(recs[i].lane) * LANE_PITCH;
      dx = int'(pix_x) - x0;
      dy = int'(pix_y) - int'(recs[i].y);
      if (recs[i].state == SLOT_FALL && dx >= 0 && dx < SPRITE_SIZE
          && dy >= 0 && dy < SPRITE_SIZE) begin
        pix_hit_c  = 1'b1;
        pix_lane_c = recs[i].lane[LW-1:0];
        pix_u_c    = dx[5:0];
        pix_v_c    = dy[5:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      score          <= '0;
      miss_count     <= '0;
      combo          <= '0;
      judge_valid_q  <= 1'b0;
      judge_result_q <= JUDGE_EMPTY;
      pix_hit        <= 1'b0;
      pix_lane       <= '0;
      pix_u          <= '0;
      pix_v          <= '0;
    end else begin
      if (key_hit) score <= sat_add16(score, score_inc);
      if (|expire_v) miss_count <= sat_add16(miss_count, exp_cnt);
      combo          <= combo_next;
      judge_valid_q  <= bus.key_valid || (|expire_v);
      judge_result_q <= judge_next;
      pix_hit        <= pix_hit_c;
      pix_lane       <= pix_lane_c;
      pix_u          <= pix_u_c;
      pix_v          <= pix_v_c;
    end
  end

  assign bus.judge_valid  = judge_valid_q;
  assign bus.judge_result = judge_result_q;

endmodule

// File: tb/tb_note_lane_engine.sv
// Directed testbench for note_lane_engine with default parameters.
// Expected score/combo values follow the NOTE_ENGINE_COMBO_EN build option.
module tb_note_lane_engine;

`ifdef NOTE_ENGINE_COMBO_EN
  localparam bit COMBO_EN = 1'b1;
`else
  localparam bit COMBO_EN = 1'b0;
`endif

  localparam int J_MISS = 0, J_HIT = 1, J_WRONG = 2, J_EMPTY = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        frame_tick;
  logic [9:0]  pix_x;
  logic [8:0]  pix_y;
  logic        pix_hit;
  logic [1:0]  pix_lane;
  logic [5:0]  pix_u, pix_v;
  logic [15:0] score, miss_count;
  logic [7:0]  combo;

  int n_vec = 0;
  int n_bad = 0;

  note_lane_engine_if #(.LW(2)) bus ();

  note_lane_engine dut (
    .clk        (clk),
    .reset      (reset),
    .frame_tick (frame_tick),
    .bus        (bus),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .pix_hit    (pix_hit),
    .pix_lane   (pix_lane),
    .pix_u      (pix_u),
    .pix_v      (pix_v),
    .score      (score),
    .miss_count (miss_count),
    .combo      (combo)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    int         x;
    int         y;
    logic       hit;
    int         lane;
    int         u;
    int         v;
  } pix_vec_t;

  pix_vec_t pv [8];

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic ticks(input int n);
    frame_tick = 1'b1;
    repeat (n) step();
    frame_tick = 1'b0;
  endtask

  task automatic spawn(input int lane);
    bus.spawn_valid = 1'b1;
    bus.spawn_lane  = 2'(lane);
    step();
    bus.spawn_valid = 1'b0;
  endtask

  task automatic key(input int lane, input logic with_tick);
    bus.key_valid = 1'b1;
    bus.key_lane  = 2'(lane);
    frame_tick    = with_tick;
    step();
    bus.key_valid = 1'b0;
    frame_tick    = 1'b0;
  endtask

  task automatic judge_chk(input string name, input int exp_res);
    chk({name, "_valid"}, int'(bus.judge_valid), 1);
    chk({name, "_result"}, int'(bus.judge_result), exp_res);
  endtask

  task automatic pix_chk(input string name, input int x, input int y, input logic eh,
                         input int el, input int eu, input int ev);
    pix_x = 10'(x);
    pix_y = 9'(y);
    step();
    chk({name, "_hit"}, int'(pix_hit), int'(eh));
    if (eh) begin
      chk({name, "_lane"}, int'(pix_lane), el);
      chk({name, "_u"}, int'(pix_u), eu);
      chk({name, "_v"}, int'(pix_v), ev);
    end
  endtask

  initial begin
    int m_score;
    int m_combo;

    pv[0] = '{"pix_origin",   320,  0, 1'b1, 2,  0,  0};
    pv[1] = '{"pix_far",      369, 49, 1'b1, 2, 49, 49};
    pv[2] = '{"pix_mid",      345, 20, 1'b1, 2, 25, 20};
    pv[3] = '{"pix_x_right",  370,  0, 1'b0, 0,  0,  0};
    pv[4] = '{"pix_x_left",   319, 10, 1'b0, 0,  0,  0};
    pv[5] = '{"pix_y_below",  330, 50, 1'b0, 0,  0,  0};
    pv[6] = '{"pix_lane0",    160,  0, 1'b0, 0,  0,  0};
    pv[7] = '{"pix_lane3",    400,  5, 1'b0, 0,  0,  0};

    reset           = 1'b1;
    frame_tick      = 1'b1;
    bus.spawn_valid = 1'b1;
    bus.spawn_lane  = 2'd2;
    bus.key_valid   = 1'b1;
    bus.key_lane    = 2'd2;
    pix_x           = 10'd320;
    pix_y           = 9'd0;

    // Reset overrides same-cycle spawn/key/tick
    step();
    step();
    reset           = 1'b0;
    frame_tick      = 1'b0;
    bus.spawn_valid = 1'b0;
    bus.key_valid   = 1'b0;
    #1;
    chk("rst_score", int'(score), 0);
    chk("rst_miss", int'(miss_count), 0);
    chk("rst_combo", int'(combo), 0);
    chk("rst_jvalid", int'(bus.judge_valid), 0);
    chk("rst_jresult", int'(bus.judge_result), J_EMPTY);
    chk("rst_pix_hit", int'(pix_hit), 0);
    chk("rst_ready", int'(bus.spawn_ready), 1);
    pix_chk("rst_no_spawn", 320, 0, 1'b0, 0, 0, 0);

    // Spawn lane 2, then table-driven pixel lookups against y=0
    spawn(2);
    for (int i = 0; i < 8; i++) begin
      pix_chk(pv[i].name, pv[i].x, pv[i].y, pv[i].hit, pv[i].lane, pv[i].u, pv[i].v);
    end

    // spawn_ready: low during frame_tick, low when all slots full
    do_reset();
    frame_tick = 1'b1;
    #1;
    chk("ready_tick_low", int'(bus.spawn_ready), 0);
    frame_tick = 1'b0;
    #1;
    chk("ready_idle_high", int'(bus.spawn_ready), 1);
    for (int i = 0; i < 4; i++) spawn(i);
    #1;
    chk("ready_full_low", int'(bus.spawn_ready), 0);
    pix_chk("full_lane3", 400, 0, 1'b1, 3, 0, 0);

    // HIT at y=400
    do_reset();
    chk("rst2_score", int'(score), 0);
    spawn(2);
    ticks(400);
    pix_chk("y400_top", 320, 400, 1'b1, 2, 0, 0);
    pix_chk("y400_above", 320, 399, 1'b0, 0, 0, 0);
    key(2, 1'b0);
    judge_chk("hit400", J_HIT);
    chk("hit400_score", int'(score), 1);
    chk("hit400_combo", int'(combo), COMBO_EN ? 1 : 0);
    pix_chk("hit400_gone", 320, 400, 1'b0, 0, 0, 0);
    chk("hit400_pulse_end", int'(bus.judge_valid), 0);

    // WRONG outside window and wrong lane, window lower edge
    do_reset();
    spawn(2);
    ticks(300);
    key(2, 1'b0);
    judge_chk("wrong300", J_WRONG);
    chk("wrong300_score", int'(score), 0);
    chk("wrong300_combo", int'(combo), 0);
    pix_chk("wrong300_remains", 320, 300, 1'b1, 2, 0, 0);
    ticks(59);
    key(2, 1'b0);
    judge_chk("wrong359", J_WRONG);
    ticks(1);
    key(1, 1'b0);
    judge_chk("wrong_lane360", J_WRONG);
    key(2, 1'b0);
    judge_chk("hit360", J_HIT);
    chk("hit360_score", int'(score), 1);

    // Expiry: single note, then two notes expiring on the same tick
    do_reset();
    spawn(2);
    ticks(479);
    chk("pre_exp_miss", int'(miss_count), 0);
    chk("pre_exp_jvalid", int'(bus.judge_valid), 0);
    pix_chk("y479", 320, 479 - 256, 1'b0, 0, 0, 0);
    ticks(1);
    judge_chk("miss1", J_MISS);
    chk("miss1_count", int'(miss_count), 1);
    pix_chk("miss1_gone_lane2", 320, 0, 1'b0, 0, 0, 0);
    spawn(2);
    spawn(1);
    ticks(480);
    judge_chk("miss2", J_MISS);
    chk("miss2_count", int'(miss_count), 3);
    step();
    chk("miss2_one_pulse", int'(bus.judge_valid), 0);

    // Key with tick at y=440: judged pre-increment, no expiry
    do_reset();
    spawn(2);
    ticks(440);
    key(2, 1'b1);
    judge_chk("hit440_tick", J_HIT);
    chk("hit440_score", int'(score), 1);
    step();
    chk("hit440_no_miss_pulse", int'(bus.judge_valid), 0);
    chk("hit440_miss_count", int'(miss_count), 0);
    key(1, 1'b0);
    judge_chk("empty", J_EMPTY);
    spawn(0);
    ticks(441);
    key(0, 1'b0);
    judge_chk("wrong441", J_WRONG);

    // Key judgement wins over same-cycle expiry MISS
    do_reset();
    spawn(2);
    ticks(100);
    spawn(1);
    ticks(379);
    key(1, 1'b1);
    judge_chk("prio_wrong", J_WRONG);
    chk("prio_miss_count", int'(miss_count), 1);
    step();
    chk("prio_no_late_miss", int'(bus.judge_valid), 0);
    key(1, 1'b0);
    judge_chk("prio_hit380", J_HIT);

    // Equal y: lowest slot index is the target
    do_reset();
    spawn(1);
    spawn(2);
    ticks(400);
    key(2, 1'b0);
    judge_chk("tie_wrong", J_WRONG);
    key(1, 1'b0);
    judge_chk("tie_hit_slot0", J_HIT);
    key(2, 1'b0);
    judge_chk("tie_hit_slot1", J_HIT);
    chk("tie_score", int'(score), 2);

    // Nine consecutive hits
    do_reset();
    m_score = 0;
    m_combo = 0;
    for (int i = 0; i < 9; i++) begin
      spawn(i % 4);
      ticks(400);
      key(i % 4, 1'b0);
      judge_chk($sformatf("streak%0d", i), J_HIT);
      if (COMBO_EN) begin
        m_score += 1 + (((m_combo >> 3) > 3) ? 3 : (m_combo >> 3));
        m_combo += 1;
      end else begin
        m_score += 1;
      end
    end
    chk("streak_score", int'(score), m_score);
    chk("streak_score_abs", int'(score), COMBO_EN ? 10 : 9);
    chk("streak_combo", int'(combo), m_combo);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
